// File: rtl/vstu_axi_write_responder_if.sv
// AW/W/B slave bundle plus the SRAM-style write port of the responder.
// slave: responder side; master: traffic source and memory model side.
interface vstu_axi_write_responder_if #(
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned AxiAddrWidth = 32,
  parameter int unsigned AxiIdWidth   = 4,
  parameter int unsigned MemAddrWidth = 16
) ();
  localparam int unsigned StrbW = AxiDataWidth / 8;

  logic                    aw_valid_i;
  logic                    aw_ready_o;
  logic [AxiAddrWidth-1:0] aw_addr_i;
  logic [7:0]              aw_len_i;
  logic [2:0]              aw_size_i;
  logic [1:0]              aw_burst_i;
  logic [AxiIdWidth-1:0]   aw_id_i;

  logic                    w_valid_i;
  logic                    w_ready_o;
  logic [AxiDataWidth-1:0] w_data_i;
  logic [StrbW-1:0]        w_strb_i;
  logic                    w_last_i;

  logic                    b_valid_o;
  logic                    b_ready_i;
  logic [AxiIdWidth-1:0]   b_id_o;
  logic [1:0]              b_resp_o;

  logic                    mem_req_o;
  logic                    mem_gnt_i;
  logic [MemAddrWidth-1:0] mem_addr_o;
  logic [AxiDataWidth-1:0] mem_wdata_o;
  logic [StrbW-1:0]        mem_be_o;

  modport slave (
    input  aw_valid_i, aw_addr_i, aw_len_i,
    input  aw_size_i, aw_burst_i, aw_id_i,
    output aw_ready_o,
    input  w_valid_i, w_data_i, w_strb_i, w_last_i,
    output w_ready_o,
    output b_valid_o, b_id_o, b_resp_o,
    input  b_ready_i,
    output mem_req_o, mem_addr_o, mem_wdata_o, mem_be_o,
    input  mem_gnt_i
  );

  modport master (
    output aw_valid_i, aw_addr_i, aw_len_i,
    output aw_size_i, aw_burst_i, aw_id_i,
    input  aw_ready_o,
    output w_valid_i, w_data_i, w_strb_i, w_last_i,
    input  w_ready_o,
    input  b_valid_o, b_id_o, b_resp_o,
    output b_ready_i,
    input  mem_req_o, mem_addr_o, mem_wdata_o, mem_be_o,
    output mem_gnt_i
  );
endinterface

// File: rtl/vstu_axi_write_responder.sv
// AXI write responder: queues AW, writes each W beat to memory, returns B.
// Ports: clk_i, rst_i (async high), bus (slave modport), busy_o.
module vstu_axi_write_responder #(
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned AxiAddrWidth = 32,
  parameter int unsigned AxiIdWidth   = 4,
  parameter int unsigned AwFifoDepth  = 4,
  parameter int unsigned BFifoDepth   = 4,
  parameter int unsigned MemAddrWidth = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  vstu_axi_write_responder_if.slave bus,
  output logic busy_o
);
  localparam int unsigned StrbW  = AxiDataWidth / 8;
  localparam int unsigned OffW   = $clog2(StrbW);
  localparam int unsigned AwPtrW = $clog2(AwFifoDepth);
  localparam int unsigned BPtrW  = $clog2(BFifoDepth);

  localparam logic [1:0] BurstFixed = 2'd0;
  localparam logic [1:0] BurstIncr  = 2'd1;
  localparam logic [1:0] RespOkay   = 2'd0;
  localparam logic [1:0] RespSlverr = 2'd2;

  typedef struct packed {
    logic [AxiAddrWidth-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic [AxiIdWidth-1:0]   id;
  } aw_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0] id;
    logic [1:0]            resp;
  } b_t;

  typedef enum logic {
    IDLE,
    BURST
  } state_e;

  state_e state_q, state_d;

  // Held low through reset so aw_ready_o only rises after release.
  logic live_q;

  // AW FIFO
  aw_t             aw_mem [AwFifoDepth];
  logic [AwPtrW:0] aw_wptr_q, aw_rptr_q;
  logic            aw_empty, aw_full;
  logic            aw_push, aw_pop;
  aw_t             aw_in, aw_head;

  // B FIFO
  b_t             b_mem [BFifoDepth];
  logic [BPtrW:0] b_wptr_q, b_rptr_q;
  logic           b_empty, b_full;
  logic           b_push, b_pop;
  b_t             b_in, b_head;

  // Active burst
  aw_t        act_q;
  logic [8:0] beat_cnt_q;
  logic       cfg_err_q;
  logic       last_err_q;
  logic       head_err;

  logic       is_final, last_bad;
  logic       beat_fire;
  logic       mem_req, w_ready;

  logic [AxiAddrWidth-1:0] size_mask;
  logic [AxiAddrWidth-1:0] aligned;
  logic [AxiAddrWidth-1:0] step;
  logic [AxiAddrWidth-1:0] beat_addr;

  assign aw_empty = aw_wptr_q == aw_rptr_q;
  assign aw_full  =
    (aw_wptr_q[AwPtrW] != aw_rptr_q[AwPtrW]) &&
    (aw_wptr_q[AwPtrW-1:0] == aw_rptr_q[AwPtrW-1:0]);

  assign b_empty = b_wptr_q == b_rptr_q;
  assign b_full  =
    (b_wptr_q[BPtrW] != b_rptr_q[BPtrW]) &&
    (b_wptr_q[BPtrW-1:0] == b_rptr_q[BPtrW-1:0]);

  assign aw_in.addr  = bus.aw_addr_i;
  assign aw_in.len   = bus.aw_len_i;
  assign aw_in.size  = bus.aw_size_i;
  assign aw_in.burst = bus.aw_burst_i;
  assign aw_in.id    = bus.aw_id_i;

  assign aw_head = aw_mem[aw_rptr_q[AwPtrW-1:0]];
  assign b_head  = b_mem[b_rptr_q[BPtrW-1:0]];

  assign bus.aw_ready_o = live_q && !aw_full;
  assign aw_push = bus.aw_valid_i && bus.aw_ready_o;

  assign bus.b_valid_o = !b_empty;
  assign bus.b_id_o    = b_head.id;
  assign bus.b_resp_o  = b_head.resp;
  assign b_pop = bus.b_valid_o && bus.b_ready_i;

  // Oversized beats and WRAP/reserved bursts are drained, not written.
  assign head_err =
    (aw_head.size > 3'(OffW)) ||
    (aw_head.burst != BurstFixed &&
     aw_head.burst != BurstIncr);

  // Beat n > 0 of INCR steps from the size-aligned start address.
  assign size_mask =
    (AxiAddrWidth'(1) << act_q.size) - AxiAddrWidth'(1);
  assign aligned = act_q.addr & ~size_mask;
  assign step =
    AxiAddrWidth'(beat_cnt_q) << act_q.size;

  always_comb begin
    beat_addr = act_q.addr;
    if (act_q.burst == BurstIncr && beat_cnt_q != 9'd0)
      beat_addr = aligned + step;
  end

  assign is_final = beat_cnt_q == {1'b0, act_q.len};
  assign last_bad = bus.w_last_i != is_final;

  assign b_in.id   = act_q.id;
  assign b_in.resp =
    (cfg_err_q || last_err_q || last_bad) ?
    RespSlverr : RespOkay;

  always_comb begin
    state_d   = state_q;
    aw_pop    = 1'b0;
    mem_req   = 1'b0;
    w_ready   = 1'b0;
    beat_fire = 1'b0;
    b_push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!aw_empty) begin
          aw_pop  = 1'b1;
          state_d = BURST;
        end
      end
      BURST: begin
        if (cfg_err_q) begin
          w_ready = !b_full;
        end else begin
          mem_req = bus.w_valid_i && !b_full;
          w_ready = bus.mem_gnt_i && !b_full;
        end
        beat_fire = bus.w_valid_i && w_ready;
        if (beat_fire && is_final) begin
          b_push  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.w_ready_o = w_ready;
  assign bus.mem_req_o = mem_req;

  always_comb begin
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    bus.mem_be_o    = '0;
    if (state_q == BURST) begin
      bus.mem_addr_o  =
        beat_addr[MemAddrWidth+OffW-1:OffW];
      bus.mem_wdata_o = bus.w_data_i;
      bus.mem_be_o    = bus.w_strb_i;
    end
  end

  assign busy_o =
    !aw_empty || state_q == BURST || !b_empty;

  always_ff @(posedge clk_i) begin
    if (aw_push)
      aw_mem[aw_wptr_q[AwPtrW-1:0]] <= aw_in;
    if (b_push)
      b_mem[b_wptr_q[BPtrW-1:0]] <= b_in;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      live_q     <= 1'b0;
      aw_wptr_q  <= '0;
      aw_rptr_q  <= '0;
      b_wptr_q   <= '0;
      b_rptr_q   <= '0;
      act_q      <= '0;
      beat_cnt_q <= '0;
      cfg_err_q  <= 1'b0;
      last_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      if (aw_push) aw_wptr_q <= aw_wptr_q + 1'b1;
      if (aw_pop)  aw_rptr_q <= aw_rptr_q + 1'b1;
      if (b_push)  b_wptr_q  <= b_wptr_q + 1'b1;
      if (b_pop)   b_rptr_q  <= b_rptr_q + 1'b1;
      if (aw_pop) begin
        act_q      <= aw_head;
        beat_cnt_q <= '0;
        cfg_err_q  <= head_err;
        last_err_q <= 1'b0;
      end else if (beat_fire) begin
        if (last_bad) last_err_q <= 1'b1;
        if (!is_final) beat_cnt_q <= beat_cnt_q + 9'd1;
      end
    end
  end
endmodule

// File: tb/tb_vstu_axi_write_responder.sv
// Scoreboard bench for vstu_axi_write_responder.
// Directed bursts; monitors check memory writes and B responses.
module tb_vstu_axi_write_responder;
  logic clk;
  logic rst;
  logic busy;

  vstu_axi_write_responder_if #(
    .AxiDataWidth(64), .AxiAddrWidth(32),
    .AxiIdWidth(4), .MemAddrWidth(16)
  ) bus ();

  vstu_axi_write_responder #(
    .AxiDataWidth(64), .AxiAddrWidth(32),
    .AxiIdWidth(4), .AwFifoDepth(4),
    .BFifoDepth(4), .MemAddrWidth(16)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus),
    .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [63:0] d;
    logic [7:0]  be;
  } mexp_t;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } bexp_t;

  mexp_t mq[$];
  bexp_t bq[$];

  int total;
  int passed;
  int req_cnt;
  int wr_no_gnt;
  bit toggle;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  task automatic bad(string name);
    total++;
    $display("FAIL %s", name);
  endtask

  // Memory write monitor
  always @(negedge clk) begin
    if (!rst && bus.mem_req_o) req_cnt++;
    if (!rst && bus.w_ready_o && !bus.mem_gnt_i
        && toggle) wr_no_gnt++;
    if (!rst && bus.mem_req_o && bus.mem_gnt_i) begin
      if (mq.size() == 0) begin
        bad("unexpected_mem_write");
      end else begin
        mexp_t e;
        e = mq.pop_front();
        chk("mem_addr", 64'(bus.mem_addr_o), 64'(e.a));
        chk("mem_wdata", bus.mem_wdata_o, e.d);
        chk("mem_be", 64'(bus.mem_be_o), 64'(e.be));
      end
    end
  end

  // B monitor
  always @(negedge clk) begin
    if (!rst && bus.b_valid_o && bus.b_ready_i) begin
      if (bq.size() == 0) begin
        bad("unexpected_b");
      end else begin
        bexp_t e;
        e = bq.pop_front();
        chk("b_id", 64'(bus.b_id_o), 64'(e.id));
        chk("b_resp", 64'(bus.b_resp_o), 64'(e.resp));
      end
    end
  end

  // Grant generator: constant 1 or toggling
  always @(posedge clk) begin
    #1;
    if (toggle) bus.mem_gnt_i = ~bus.mem_gnt_i;
    else bus.mem_gnt_i = 1'b1;
  end

  task automatic send_aw(logic [31:0] addr,
                         logic [7:0] len,
                         logic [2:0] size,
                         logic [1:0] burst,
                         logic [3:0] id);
    bit ok;
    ok = 1'b0;
    bus.aw_valid_i = 1'b1;
    bus.aw_addr_i  = addr;
    bus.aw_len_i   = len;
    bus.aw_size_i  = size;
    bus.aw_burst_i = burst;
    bus.aw_id_i    = id;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.aw_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.aw_valid_i = 1'b0;
    if (!ok) bad("aw_timeout");
  endtask

  task automatic send_w(logic [63:0] data,
                        logic [7:0] strb,
                        logic last,
                        bit exp_mem,
                        logic [15:0] exp_a);
    bit ok;
    ok = 1'b0;
    if (exp_mem) begin
      mexp_t e;
      e.a  = exp_a;
      e.d  = data;
      e.be = strb;
      mq.push_back(e);
    end
    bus.w_valid_i = 1'b1;
    bus.w_data_i  = data;
    bus.w_strb_i  = strb;
    bus.w_last_i  = last;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.w_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.w_valid_i = 1'b0;
    if (!ok) bad("w_timeout");
  endtask

  task automatic exp_b(logic [3:0] id, logic [1:0] r);
    bexp_t e;
    e.id   = id;
    e.resp = r;
    bq.push_back(e);
  endtask

  task automatic wait_idle(string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, 64'(ok), 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    passed = 0;
    req_cnt = 0;
    wr_no_gnt = 0;
    toggle = 1'b0;
    rst = 1'b1;
    bus.aw_valid_i = 1'b0;
    bus.aw_addr_i  = '0;
    bus.aw_len_i   = '0;
    bus.aw_size_i  = '0;
    bus.aw_burst_i = '0;
    bus.aw_id_i    = '0;
    bus.w_valid_i  = 1'b0;
    bus.w_data_i   = '0;
    bus.w_strb_i   = '0;
    bus.w_last_i   = 1'b0;
    bus.b_ready_i  = 1'b1;
    bus.mem_gnt_i  = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_aw_ready", 64'(bus.aw_ready_o), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_b_valid", 64'(bus.b_valid_o), 64'd0);
    rst = 1'b0;
    #1;
    chk("rel_aw_ready_low", 64'(bus.aw_ready_o), 64'd0);
    @(posedge clk);
    #1;
    chk("rel_aw_ready_high", 64'(bus.aw_ready_o), 64'd1);

    // Single INCR burst
    exp_b(4'd5, 2'd0);
    send_aw(32'h100, 8'd3, 3'd3, 2'd1, 4'd5);
    chk("busy_active", 64'(busy), 64'd1);
    send_w(64'h1111_2222_3333_4444, 8'hFF, 1'b0, 1, 16'h20);
    send_w(64'h5555_6666_7777_8888, 8'h0F, 1'b0, 1, 16'h21);
    send_w(64'h9999_AAAA_BBBB_CCCC, 8'h00, 1'b0, 1, 16'h22);
    send_w(64'hDDDD_EEEE_FFFF_0000, 8'hA5, 1'b1, 1, 16'h23);
    wait_idle("incr_idle");

    // Unaligned narrow INCR
    exp_b(4'd6, 2'd0);
    send_aw(32'h103, 8'd2, 3'd1, 2'd1, 4'd6);
    send_w(64'h0123_4567_89AB_CDEF, 8'h08, 1'b0, 1, 16'h20);
    send_w(64'hFEDC_BA98_7654_3210, 8'h30, 1'b0, 1, 16'h20);
    send_w(64'h0F0F_0F0F_0F0F_0F0F, 8'hC0, 1'b1, 1, 16'h20);
    wait_idle("narrow_idle");

    // Backpressure: B blocked, grant toggling
    bus.b_ready_i = 1'b0;
    toggle = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_b(4'(k + 1), 2'd0);
      send_aw(32'h400 + 32'(k * 8), 8'd0, 3'd3,
              2'd1, 4'(k + 1));
    end
    @(negedge clk);
    chk("aw_full_ready", 64'(bus.aw_ready_o), 64'd0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++)
      send_w(64'(k) + 64'hA000, 8'hFF, 1'b1, 1,
             16'h80 + 16'(k));
    begin
      int rdy;
      rdy = 0;
      bus.w_valid_i = 1'b1;
      bus.w_last_i  = 1'b1;
      repeat (8) begin
        @(negedge clk);
        if (bus.w_ready_o) rdy++;
      end
      chk("b_full_w_ready", 64'(rdy), 64'd0);
      chk("b_full_no_b_yet", 64'(bq.size()), 64'd5);
      @(posedge clk);
      #1;
    end
    bus.b_ready_i = 1'b1;
    send_w(64'hA004, 8'hFF, 1'b1, 1, 16'h84);
    toggle = 1'b0;
    chk("w_ready_follows_gnt", 64'(wr_no_gnt), 64'd0);
    wait_idle("bp_idle");

    // Oversized beat size: drained, no writes
    req_cnt = 0;
    exp_b(4'd7, 2'd2);
    send_aw(32'h0, 8'd1, 3'd4, 2'd1, 4'd7);
    send_w(64'h1, 8'hFF, 1'b0, 0, 16'h0);
    send_w(64'h2, 8'hFF, 1'b1, 0, 16'h0);
    wait_idle("size_err_idle");
    chk("size_err_no_req", 64'(req_cnt), 64'd0);

    // WRAP burst
    exp_b(4'd8, 2'd2);
    send_aw(32'h40, 8'd1, 3'd3, 2'd2, 4'd8);
    send_w(64'h3, 8'hFF, 1'b0, 0, 16'h0);
    send_w(64'h4, 8'hFF, 1'b1, 0, 16'h0);
    wait_idle("wrap_idle");
    chk("wrap_no_req", 64'(req_cnt), 64'd0);

    // Early w_last: writes continue, resp SLVERR
    exp_b(4'd9, 2'd2);
    send_aw(32'h200, 8'd2, 3'd3, 2'd1, 4'd9);
    send_w(64'h10, 8'hFF, 1'b0, 1, 16'h40);
    send_w(64'h11, 8'hFF, 1'b1, 1, 16'h41);
    send_w(64'h12, 8'hFF, 1'b0, 1, 16'h42);
    wait_idle("last_err_idle");

    // 256-beat burst
    exp_b(4'd3, 2'd0);
    send_aw(32'h0, 8'd255, 3'd3, 2'd1, 4'd3);
    for (int i = 0; i < 256; i++)
      send_w({32'hC0DE_0000, 32'(i)}, 8'(i), i == 255,
             1, 16'(i));
    wait_idle("long_idle");

    // Reset mid-burst: no B for the dropped burst
    send_aw(32'h300, 8'd3, 3'd3, 2'd1, 4'd10);
    send_w(64'hB0, 8'hFF, 1'b0, 1, 16'h60);
    send_w(64'hB1, 8'hFF, 1'b0, 1, 16'h61);
    bus.w_valid_i = 1'b1;
    bus.w_last_i  = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_mem_req", 64'(bus.mem_req_o), 64'd0);
    chk("mid_rst_w_ready", 64'(bus.w_ready_o), 64'd0);
    chk("mid_rst_aw_ready", 64'(bus.aw_ready_o), 64'd0);
    chk("mid_rst_b_valid", 64'(bus.b_valid_o), 64'd0);
    bus.w_valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_no_b", 64'(bus.b_valid_o), 64'd0);
    exp_b(4'd11, 2'd0);
    send_aw(32'h308, 8'd0, 3'd3, 2'd1, 4'd11);
    send_w(64'hC1, 8'h3C, 1'b1, 1, 16'h61);
    wait_idle("post_rst_idle");

    repeat (3) @(posedge clk);
    chk("mem_queue_drained", 64'(mq.size()), 64'd0);
    chk("b_queue_drained", 64'(bq.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule
